// File: rtl/fb_rd_arbiter.sv
// fb_rd_arbiter: shares the frame-buffer read port between the display
// (requester 0, priority) and the streamer (requester 1).
// Each issued read is tagged with its owner, and the tag is carried
// RD_LAT cycles so that the rvalid strobe lines up with fb_dout.
// Optional build macro FB_ARB_STARVE_GUARD_EN enables the starvation guard.
// With the guard, requester 1 is forced through after MAX_WAIT refused cycles.
// Without the macro, arbitration is strict priority.
module fb_rd_arbiter #(
    parameter int AW       = 13,
    parameter int DW       = 12,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] fb_addr,
    input  logic [DW-1:0] fb_dout,
    output logic [15:0]   m1_stall_cnt
);

    // Out-of-range parameters would break the tag pipeline or the guard
    // counter, so they are rejected at elaboration.
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("fb_rd_arbiter: RD_LAT must be 1..4");
    end
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("fb_rd_arbiter: MAX_WAIT must be 1..255");
    end

    logic              force_m1;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_own;

`ifdef FB_ARB_STARVE_GUARD_EN
    // wait_left holds the number of refusals left before requester 1 is
    // forced through. It is a down-counter reloaded with MAX_WAIT, so the
    // terminal count of zero is the same point as MAX_WAIT refused cycles.
    logic [7:0] wait_left;

    assign force_m1 = m1_req && (wait_left == 8'd0);

    // Guard timer: count down on each refused cycle, reload when served or idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_left <= 8'(MAX_WAIT);
        end else if (!m1_req || m1_gnt) begin
            wait_left <= 8'(MAX_WAIT);
        end else if (wait_left != 8'd0) begin
            wait_left <= wait_left - 8'd1;
        end
    end
`else
    assign force_m1 = 1'b0;
`endif

    // Grants are combinational (zero latency) and held off during reset
    assign m0_gnt  = rst_n && m0_req && !force_m1;
    assign m1_gnt  = rst_n && m1_req && (!m0_req || force_m1);

    // Requester 0's address is parked on the port when nobody is granted
    assign fb_addr = m1_gnt ? m1_addr : m0_addr;
    assign rdata   = fb_dout;

    // Owner tag pipeline: stage 0 captures the grant, the last stage drives rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld[0] <= m0_gnt | m1_gnt;
            tag_own[0] <= m1_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end
        end
    end

    assign m0_rvalid = tag_vld[RD_LAT-1] & ~tag_own[RD_LAT-1];
    assign m1_rvalid = tag_vld[RD_LAT-1] &  tag_own[RD_LAT-1];

    // Saturating count of cycles requester 1 asked but was refused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_stall_cnt <= 16'd0;
        end else if (m1_req && !m1_gnt && (m1_stall_cnt != 16'hFFFF)) begin
            m1_stall_cnt <= m1_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fb_rd_arbiter.sv
// Bench for fb_rd_arbiter. It uses two instances on shared requester inputs:
// one with RD_LAT = 1 and one with RD_LAT = 3.
// Each instance has its own frame-buffer model, which returns data equal to
// the low 12 bits of the address.
module tb_fb_rd_arbiter;
    localparam int AW = 13;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;

    logic          g0_1, g1_1, rv0_1, rv1_1;
    logic [DW-1:0] rd_1, fd_1;
    logic [AW-1:0] fa_1;
    logic [15:0]   sc_1;
    logic          g0_3, g1_3, rv0_3, rv1_3;
    logic [DW-1:0] rd_3, fd_3;
    logic [AW-1:0] fa_3;
    logic [15:0]   sc_3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_rd_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_WAIT(15)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(g0_1), .m0_rvalid(rv0_1),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(g1_1), .m1_rvalid(rv1_1),
        .rdata(rd_1), .fb_addr(fa_1), .fb_dout(fd_1), .m1_stall_cnt(sc_1));

    fb_rd_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .MAX_WAIT(15)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(g0_3), .m0_rvalid(rv0_3),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(g1_3), .m1_rvalid(rv1_3),
        .rdata(rd_3), .fb_addr(fa_3), .fb_dout(fd_3), .m1_stall_cnt(sc_3));

    // Frame-buffer models: registered read with latency 1 and 3
    logic [AW-1:0] a1_q;
    logic [AW-1:0] a3_q [3];
    always @(posedge clk) begin
        a1_q    <= fa_1;
        a3_q[0] <= fa_3;
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end
    assign fd_1 = a1_q[DW-1:0];
    assign fd_3 = a3_q[2][DW-1:0];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
        step; step;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        step; #2;
        total++;
        if ({g0_1, g1_1, g0_3, g1_3} !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt got=%b exp=0000", {g0_1, g1_1, g0_3, g1_3});
        end
        total++;
        if ({rv0_1, rv1_1, rv0_3, rv1_3} !== 4'b0000) begin
            bad++; $display("FAIL reset_rvalid got=%b exp=0000", {rv0_1, rv1_1, rv0_3, rv1_3});
        end
        total++;
        if (sc_1 !== 16'd0 || sc_3 !== 16'd0) begin
            bad++; $display("FAIL reset_stall got=%0d/%0d exp=0", sc_1, sc_3);
        end
        do_reset;
    endtask

    task automatic test_single_m0;
        do_reset;
        for (int c = 0; c < 10; c++) begin
            m1_req = 1'b0;
            m0_req = (c < 5);
            if (c < 5) m0_addr = AW'(c);
            #2;
            total++;
            if (g0_1 !== (c < 5) || g0_3 !== (c < 5) || g1_1 !== 1'b0 || g1_3 !== 1'b0) begin
                bad++; $display("FAIL single_gnt c=%0d got=%b%b%b%b exp=%b%b00", c, g0_1, g0_3, g1_1, g1_3, c < 5, c < 5);
            end
            if (c < 5) begin
                total++;
                if (fa_1 !== AW'(c)) begin
                    bad++; $display("FAIL single_addr c=%0d got=%0d exp=%0d", c, fa_1, c);
                end
            end
            total++;
            if (rv0_1 !== (c >= 1 && c < 6) || rv1_1 !== 1'b0) begin
                bad++; $display("FAIL single_rv_l1 c=%0d got=%b%b exp=%b0", c, rv0_1, rv1_1, c >= 1 && c < 6);
            end
            if (c >= 1 && c < 6) begin
                total++;
                if (rd_1 !== DW'(c - 1)) begin
                    bad++; $display("FAIL single_rdata_l1 c=%0d got=%0d exp=%0d", c, rd_1, c - 1);
                end
            end
            total++;
            if (rv0_3 !== (c >= 3 && c < 8) || rv1_3 !== 1'b0) begin
                bad++; $display("FAIL single_rv_l3 c=%0d got=%b%b exp=%b0", c, rv0_3, rv1_3, c >= 3 && c < 8);
            end
            if (c >= 3 && c < 8) begin
                total++;
                if (rd_3 !== DW'(c - 3)) begin
                    bad++; $display("FAIL single_rdata_l3 c=%0d got=%0d exp=%0d", c, rd_3, c - 3);
                end
            end
            step;
        end
    endtask

    task automatic test_interleave;
        logic          pat [4];
        logic [AW-1:0] ea  [4];
        int            k;
        pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0;
        for (int i = 0; i < 4; i++) ea[i] = pat[i] ? AW'(200 + i) : AW'(100 + i);
        do_reset;
        for (int c = 0; c < 9; c++) begin
            if (c < 4) begin
                m0_req = ~pat[c]; m1_req = pat[c];
                if (pat[c]) m1_addr = ea[c]; else m0_addr = ea[c];
            end else begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            #2;
            if (c < 4) begin
                total++;
                if (g1_3 !== pat[c] || g0_3 !== ~pat[c] || fa_3 !== ea[c]) begin
                    bad++; $display("FAIL ilv_gnt c=%0d got=%b%b a=%0d exp=%b%b a=%0d", c, g0_3, g1_3, fa_3, ~pat[c], pat[c], ea[c]);
                end
            end
            k = c - 3;
            total++;
            if (k >= 0 && k < 4) begin
                if (rv0_3 !== ~pat[k] || rv1_3 !== pat[k] || rd_3 !== ea[k][DW-1:0]) begin
                    bad++; $display("FAIL ilv_l3 c=%0d got=%b%b d=%0d exp=%b%b d=%0d", c, rv0_3, rv1_3, rd_3, ~pat[k], pat[k], ea[k][DW-1:0]);
                end
            end else if ({rv0_3, rv1_3} !== 2'b00) begin
                bad++; $display("FAIL ilv_l3_idle c=%0d got=%b%b exp=00", c, rv0_3, rv1_3);
            end
            k = c - 1;
            total++;
            if (k >= 0 && k < 4) begin
                if (rv0_1 !== ~pat[k] || rv1_1 !== pat[k] || rd_1 !== ea[k][DW-1:0]) begin
                    bad++; $display("FAIL ilv_l1 c=%0d got=%b%b d=%0d exp=%b%b d=%0d", c, rv0_1, rv1_1, rd_1, ~pat[k], pat[k], ea[k][DW-1:0]);
                end
            end else if ({rv0_1, rv1_1} !== 2'b00) begin
                bad++; $display("FAIL ilv_l1_idle c=%0d got=%b%b exp=00", c, rv0_1, rv1_1);
            end
            step;
        end
    endtask

    task automatic test_reset_inflight;
        do_reset;
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = AW'(7); m1_addr = AW'(9);
        step;
        m0_req = 1'b0;
        step;
        m1_req = 1'b0;
        #2;
        total++;
        if (rv1_1 !== 1'b1 || sc_1 !== 16'd1) begin
            bad++; $display("FAIL inflight_pre got rv1=%b stall=%0d exp rv1=1 stall=1", rv1_1, sc_1);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({rv0_1, rv1_1, rv0_3, rv1_3} !== 4'b0000) begin
            bad++; $display("FAIL inflight_clear got=%b exp=0000", {rv0_1, rv1_1, rv0_3, rv1_3});
        end
        total++;
        if (sc_1 !== 16'd0 || sc_3 !== 16'd0) begin
            bad++; $display("FAIL inflight_stall got=%0d/%0d exp=0", sc_1, sc_3);
        end
        step;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            total++;
            if ({rv0_1, rv1_1, rv0_3, rv1_3} !== 4'b0000) begin
                bad++; $display("FAIL inflight_stale c=%0d got=%b exp=0000", c, {rv0_1, rv1_1, rv0_3, rv1_3});
            end
            step;
        end
    endtask

`ifdef FB_ARB_STARVE_GUARD_EN
    task automatic test_starve_guard;
        int misses;
        misses = 0;
        do_reset;
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = AW'(3); m1_addr = AW'(5);
        for (int c = 0; c < 48; c++) begin
            #2;
            total++;
            if (g1_1 !== ((c % 16) == 15) || g0_1 !== ((c % 16) != 15)) begin
                bad++; $display("FAIL guard_gnt c=%0d got=%b%b exp=%b%b", c, g0_1, g1_1, (c % 16) != 15, (c % 16) == 15);
            end
            step;
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask
`else
    task automatic test_priority;
        do_reset;
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = AW'(11); m1_addr = AW'(22);
        for (int c = 0; c < 40; c++) begin
            #2;
            total++;
            if (g1_1 !== 1'b0 || g0_1 !== 1'b1 || fa_1 !== AW'(11)) begin
                bad++; $display("FAIL prio_hold c=%0d got=%b%b a=%0d exp=10 a=11", c, g0_1, g1_1, fa_1);
            end
            step;
        end
        m0_req = 1'b0;
        #2;
        total++;
        if (g1_1 !== 1'b1 || g0_1 !== 1'b0 || fa_1 !== AW'(22)) begin
            bad++; $display("FAIL prio_release got=%b%b a=%0d exp=01 a=22", g0_1, g1_1, fa_1);
        end
        total++;
        if (sc_1 !== 16'd40 || sc_3 !== 16'd40) begin
            bad++; $display("FAIL prio_stall got=%0d/%0d exp=40", sc_1, sc_3);
        end
        step;
        m1_req = 1'b0;
    endtask

    task automatic test_stall_saturate;
        do_reset;
        m0_req = 1'b1; m1_req = 1'b1;
        repeat (65534) step;
        total++;
        if (sc_1 !== 16'hFFFE) begin
            bad++; $display("FAIL sat_pre got=%h exp=fffe", sc_1);
        end
        step;
        total++;
        if (sc_1 !== 16'hFFFF) begin
            bad++; $display("FAIL sat_hit got=%h exp=ffff", sc_1);
        end
        repeat (4465) step;
        total++;
        if (sc_1 !== 16'hFFFF || sc_3 !== 16'hFFFF) begin
            bad++; $display("FAIL sat_hold got=%h/%h exp=ffff", sc_1, sc_3);
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_single_m0;
        test_interleave;
        test_reset_inflight;
`ifdef FB_ARB_STARVE_GUARD_EN
        test_starve_guard;
`else
        test_priority;
        test_stall_saturate;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_rd_arbiter.md
# fb_rd_arbiter

Shares the single read port of the camera frame buffer (port B, registered read) between two requesters: the VGA display (requester 0, priority) and the OLED/processing streamer (requester 1). It muxes the address onto the buffer and tags every issued read with its owner. It then returns data with a per-requester valid strobe aligned to the buffer's read latency. An optional starvation guard bounds requester 1's wait. It sits between the frame buffer and its readers, in the 50 MHz capture/display domain.

## Interface
- `AW`, 13: frame-buffer address width (80x60 = 4800 pixels).
- `DW`, 12: pixel word width (4-4-4 RGB).
- `RD_LAT`, 1: frame-buffer read latency in cycles, 1..4.
- `MAX_WAIT`, 15: cycles requester 1 may be refused before forced service, 1..255.

Ports:
- `clk`  in  1  system clock (50 MHz domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_req`  in  1  requester 0 read request (display).
- `m0_addr`  in  AW  requester 0 pixel address.
- `m0_gnt`  out  1  requester 0 read issued this cycle.
- `m0_rvalid`  out  1  `rdata` belongs to requester 0.
- `m1_req`  in  1  requester 1 read request (streamer).
- `m1_addr`  in  AW  requester 1 pixel address.
- `m1_gnt`  out  1  requester 1 read issued this cycle.
- `m1_rvalid`  out  1  `rdata` belongs to requester 1.
- `rdata`  out  DW  read data, a direct pass-through of `fb_dout`.
- `fb_addr`  out  AW  address to the frame-buffer read port.
- `fb_dout`  in  DW  frame-buffer read data.
- `m1_stall_cnt`  out  16  saturating count of cycles requester 1 was refused.

## Operation
- Arbitration is combinational each cycle:
  - `m0_req` alone: `m0_gnt` = 1.
  - `m1_req` alone: `m1_gnt` = 1.
  - Both high: requester 0 wins, except when the starvation guard forces requester 1 (see Configuration).
- At most one grant is high per cycle. Both grants are 0 while `rst_n` is low.
- `fb_addr` carries `m1_addr` when `m1_gnt` = 1 and `m0_addr` otherwise, including idle cycles.
- Owner tag pipeline: an RD_LAT-deep shift register of {valid, owner}.
  - Stage 0 loads {`m0_gnt`|`m1_gnt`, `m1_gnt`}.
  - The last stage drives `m0_rvalid` = valid & ~owner and `m1_rvalid` = valid & owner.
- A grant is a completed handshake. A requester keeping `req` high issues back-to-back reads, one per cycle, with no bubble.
- The block does not buffer data. Requesters must sample `rdata` in the cycle their `rvalid` is high.
- `m1_stall_cnt` increments on every cycle with `m1_req` = 1 and `m1_gnt` = 0, and saturates at 16'hFFFF. It is cleared only by reset.
- Reset values: `m0_rvalid` = `m1_rvalid` = 0, tag pipeline all invalid, wait counter = 0, `m1_stall_cnt` = 0.

## Timing
- Grant latency is 0: `gnt` is high in the same cycle as `req` when that requester wins.
- Read issued at edge N (address sampled) returns at N+RD_LAT. `rvalid` is high for exactly one cycle, aligned with `fb_dout`.
- Throughput is one read per cycle total, shared between the requesters.
- Reset asserted mid-operation: the tag pipeline clears immediately (async), in-flight reads are discarded, and no `rvalid` is produced for them after release.
- First grant is possible in the first cycle with `rst_n` high.
- Simultaneous `req` on both while the guard is inactive: requester 0 is served and requester 1's stall and wait counters advance.
- Requests that drop before being granted are not remembered.

## Configuration
- `FB_ARB_STARVE_GUARD_EN` defined:
  - An 8-bit wait counter increments on each refused `m1_req` cycle and clears on `m1_gnt` or when `m1_req` is low.
  - When the counter equals MAX_WAIT and `m1_req` = 1, requester 1 wins that cycle even against `m0_req`. The counter then clears.
  - Result: requester 1 waits at most MAX_WAIT cycles.
- Undefined: strict priority. The wait counter is absent and requester 1 is served only when `m0_req` = 0. `m1_stall_cnt` is still present.

## Test plan
- Single requester 0, `m0_req` held for 5 cycles, addresses 0..4, buffer returning data = address: `m0_gnt` high for all 5 cycles; `m0_rvalid` high 5 cycles starting RD_LAT later with `rdata` 0..4; `m1_rvalid` never high.
- Both requesting, guard undefined, `m0_req` held for 40 cycles: `m1_gnt` stays 0 throughout and `m1_stall_cnt` = 40. `m1_gnt` = 1 in the first cycle after `m0_req` falls.
- Both requesting continuously, guard defined, MAX_WAIT = 15: `m1_gnt` pulses once every 16 cycles, and `m0_gnt` is low exactly in those cycles.
- RD_LAT = 3 with interleaved grants (0,1,1,0): the rvalid sequence 0,1,1,0 appears three cycles later and each `rdata` matches its requester's address.
- `rst_n` pulsed low with two reads in flight: both rvalids are 0 immediately and no stale rvalid appears after release; `m1_stall_cnt` = 0.
- Stall saturation: hold requester 1 refused for 70000 cycles with guard undefined: `m1_stall_cnt` = 16'hFFFF and does not wrap.
